// File: rtl/mem_pkg.sv
// Shared definitions for the program RAM, the CPU and the run-time RAM programmer.
package mem_pkg;

  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_DEPTH  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_SET_ADDR,
    S_WRITE,
    S_CHECK,
    S_DONE
  } prog_state_t;

endpackage

// File: rtl/mem_programmer.sv
// Writes a byte stream into the program RAM through its load/store bus interface,
// optionally reading each word back and flagging the first mismatching address.
module mem_programmer
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = MEM_DEPTH,
  parameter bit VERIFY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              load,
  output logic              store,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  prog_state_t       state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              error_d;
  logic [ADDR_W-1:0] err_addr_d;

  // NOTE: every state register is assigned with <= so all of them update together
  // from the values sampled at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      addr     <= '0;
      data_q   <= '0;
      error    <= 1'b0;
      err_addr <= '0;
    end else begin
      state    <= state_d;
      addr     <= addr_d;
      data_q   <= data_d;
      error    <= error_d;
      err_addr <= err_addr_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state;
    addr_d     = addr;
    data_d     = data_q;
    error_d    = error;
    err_addr_d = err_addr;
    if (abort && busy) begin
      // Abort keeps the error record so the failing session can still be inspected.
      state_d = S_IDLE;
      addr_d  = '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d    = S_WAIT_BYTE;
            addr_d     = '0;
            error_d    = 1'b0;
            err_addr_d = '0;
          end
        end
        S_WAIT_BYTE: begin
          if (in_valid) begin
            data_d  = in_data;
            state_d = S_SET_ADDR;
          end
        end
        S_SET_ADDR: state_d = S_WRITE;
        S_WRITE, S_CHECK: begin
          if (state == S_CHECK && mem_out != data_q && !error) begin
            error_d    = 1'b1;
            err_addr_d = addr;
          end
          if (state == S_WRITE && VERIFY) begin
            state_d = S_CHECK;
          end else if (addr == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr + 1'b1;
            state_d = S_WAIT_BYTE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != S_IDLE) && (state != S_DONE);
    done     = (state == S_DONE);
    // Gated by abort so a byte offered in the abort cycle is never seen as taken.
    in_ready = (state == S_WAIT_BYTE) && !abort;
    load     = (state == S_SET_ADDR);
    store    = (state == S_WRITE);
    bus_oe   = load || store;
    bus_out  = '0;
    if (load)  bus_out = DATA_W'(addr);
    if (store) bus_out = data_q;
  end

endmodule

// File: tb/tb_mem_programmer.sv
// Directed bench: two programmers (read-back on and off), each attached to a RAM
// model and a byte source that advances whenever a byte is accepted.
module tb_mem_programmer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start    [2];
  logic       abort    [2];
  logic       in_valid [2];
  logic [7:0] in_data  [2];
  logic       in_ready [2];
  logic [7:0] mem_out  [2];
  logic [7:0] bus_out  [2];
  logic       bus_oe   [2];
  logic       load     [2];
  logic       store    [2];
  logic       busy     [2];
  logic       done     [2];
  logic       error    [2];
  logic [3:0] err_addr [2];

  logic [7:0]  bus      [2];
  logic [7:0]  ram      [2][16];
  logic [3:0]  mar      [2];
  logic [3:0]  src_idx  [2];
  logic [7:0]  src_data [2][16];
  logic [15:0] corrupt  [2];
  int          load_cnt  [2] = '{0, 0};
  int          store_cnt [2] = '{0, 0};
  int          check_cnt [2] = '{0, 0};
  bit          overlap   [2] = '{1'b0, 1'b0};

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_programmer #(.VERIFY(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .mem_out(mem_out[0]), .bus_out(bus_out[0]), .bus_oe(bus_oe[0]),
    .load(load[0]), .store(store[0]), .busy(busy[0]), .done(done[0]),
    .error(error[0]), .err_addr(err_addr[0])
  );

  mem_programmer #(.VERIFY(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .mem_out(mem_out[1]), .bus_out(bus_out[1]), .bus_oe(bus_oe[1]),
    .load(load[1]), .store(store[1]), .busy(busy[1]), .done(done[1]),
    .error(error[1]), .err_addr(err_addr[1])
  );

  // Shared bus, RAM with combinational read, and byte source per programmer.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      bus[k]     = bus_oe[k] ? bus_out[k] : 8'h00;
      mem_out[k] = corrupt[k][mar[k]] ? 8'h00 : ram[k][mar[k]];
      in_data[k] = src_data[k][src_idx[k]];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (load[k])  mar[k] <= bus[k][3:0];
      if (store[k]) ram[k][mar[k]] <= bus[k];
      if (start[k] && !busy[k]) src_idx[k] <= 4'd0;
      else if (in_valid[k] && in_ready[k]) src_idx[k] <= src_idx[k] + 4'd1;
      if (load[k])  load_cnt[k]  <= load_cnt[k] + 1;
      if (store[k]) store_cnt[k] <= store_cnt[k] + 1;
      if (busy[k] && !bus_oe[k] && !in_ready[k] && !abort[k]) check_cnt[k] <= check_cnt[k] + 1;
      if (load[k] && store[k]) overlap[k] <= 1'b1;
    end
  end

  task automatic fill_src(input int k, input logic [7:0] base);
    for (int i = 0; i < 16; i++) src_data[k][i] = base + 8'(i);
  endtask

  // Called at a negedge; pulses start and counts edges until done (bounded).
  task automatic run_session(input int k, output int cyc);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    cyc = 1;
    while (!done[k] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_ram(input int k, input string name, input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (ram[k][i] !== base + 8'(i))
        $display("FAIL %s[%0d]: got %h expected %h", name, i, ram[k][i], base + 8'(i));
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; abort[k] = 1'b0; in_valid[k] = 1'b0; corrupt[k] = 16'h0;
      mar[k] = 4'd0; src_idx[k] = 4'd0;
      for (int i = 0; i < 16; i++) begin ram[k][i] = 8'hEE; src_data[k][i] = 8'h00; end
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({in_ready[k], bus_oe[k], load[k], store[k], busy[k], done[k], error[k], err_addr[k], bus_out[k]} !== 19'h0)
        $display("FAIL reset_outputs%0d: got %b expected all zero", k,
                 {in_ready[k], bus_oe[k], load[k], store[k], busy[k], done[k], error[k], err_addr[k], bus_out[k]});
      else passed++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_verify();
    int cyc, l0, s0, c0;
    fill_src(0, 8'h10);
    in_valid[0] = 1'b1;
    l0 = load_cnt[0]; s0 = store_cnt[0]; c0 = check_cnt[0];
    run_session(0, cyc);
    total++; if (cyc !== 65) $display("FAIL full_done_latency: got %0d expected 65", cyc); else passed++;
    total++; if (load_cnt[0] - l0 !== 16) $display("FAIL full_loads: got %0d expected 16", load_cnt[0] - l0); else passed++;
    total++; if (store_cnt[0] - s0 !== 16) $display("FAIL full_stores: got %0d expected 16", store_cnt[0] - s0); else passed++;
    total++; if (check_cnt[0] - c0 !== 16) $display("FAIL full_checks: got %0d expected 16", check_cnt[0] - c0); else passed++;
    total++; if (error[0] !== 1'b0) $display("FAIL full_error: got %b expected 0", error[0]); else passed++;
    check_ram(0, "full_ram", 8'h10);
  endtask

  task automatic test_no_verify();
    int cyc, s0, c0;
    fill_src(1, 8'h10);
    in_valid[1] = 1'b1;
    s0 = store_cnt[1]; c0 = check_cnt[1];
    run_session(1, cyc);
    in_valid[1] = 1'b0;
    total++; if (cyc !== 49) $display("FAIL nv_done_latency: got %0d expected 49", cyc); else passed++;
    total++; if (store_cnt[1] - s0 !== 16) $display("FAIL nv_stores: got %0d expected 16", store_cnt[1] - s0); else passed++;
    total++; if (check_cnt[1] - c0 !== 0) $display("FAIL nv_checks: got %0d expected 0", check_cnt[1] - c0); else passed++;
    check_ram(1, "nv_ram", 8'h10);
  endtask

  task automatic test_mismatch();
    int cyc, s0;
    for (int i = 0; i < 16; i++) src_data[0][i] = 8'hA5;
    corrupt[0] = 16'h0220;
    s0 = store_cnt[0];
    run_session(0, cyc);
    corrupt[0] = 16'h0;
    total++; if (cyc !== 65) $display("FAIL mm_done_latency: got %0d expected 65", cyc); else passed++;
    total++; if (error[0] !== 1'b1) $display("FAIL mm_error: got %b expected 1", error[0]); else passed++;
    total++; if (err_addr[0] !== 4'd5) $display("FAIL mm_err_addr: got %0d expected 5", err_addr[0]); else passed++;
    total++; if (store_cnt[0] - s0 !== 16) $display("FAIL mm_stores: got %0d expected 16", store_cnt[0] - s0); else passed++;
    total++; if (ram[0][9] !== 8'hA5) $display("FAIL mm_ram9: got %h expected a5", ram[0][9]); else passed++;
  endtask

  task automatic test_backpressure();
    int n, cyc, s0;
    bit bad;
    fill_src(0, 8'h30);
    s0 = store_cnt[0];
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (!(in_ready[0] && src_idx[0] == 4'd4) && n < 200) begin @(negedge clk); n++; end
    total++; if (n >= 200) $display("FAIL bp_reach_byte4: got timeout expected wait state"); else passed++;
    in_valid[0] = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (!(in_ready[0] && busy[0] && !load[0] && !store[0] && !bus_oe[0])) bad = 1'b1;
    end
    total++; if (bad !== 1'b0) $display("FAIL bp_hold: got activity expected idle wait"); else passed++;
    in_valid[0] = 1'b1;
    cyc = 0;
    while (!done[0] && cyc < 2000) begin @(negedge clk); cyc++; end
    total++; if (done[0] !== 1'b1) $display("FAIL bp_done: got %b expected 1", done[0]); else passed++;
    total++; if (store_cnt[0] - s0 !== 16) $display("FAIL bp_stores: got %0d expected 16", store_cnt[0] - s0); else passed++;
    total++; if (error[0] !== 1'b0) $display("FAIL bp_error: got %b expected 0", error[0]); else passed++;
    check_ram(0, "bp_ram", 8'h30);
  endtask

  task automatic test_abort_restart();
    int n, cyc, s0;
    fill_src(0, 8'h50);
    corrupt[0] = 16'h0004;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (!(store[0] && mar[0] == 4'd7) && n < 200) begin @(negedge clk); n++; end
    total++; if (n >= 200) $display("FAIL ab_reach_write7: got timeout expected write of addr 7"); else passed++;
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    s0 = store_cnt[0];
    total++; if ({busy[0], done[0], store[0]} !== 3'b000) $display("FAIL ab_idle: got busy/done/store %b expected 000", {busy[0], done[0], store[0]}); else passed++;
    total++; if (ram[0][7] !== 8'h57) $display("FAIL ab_ram7: got %h expected 57", ram[0][7]); else passed++;
    total++; if ({error[0], err_addr[0]} !== {1'b1, 4'd2}) $display("FAIL ab_err_kept: got %b/%0d expected 1/2", error[0], err_addr[0]); else passed++;
    repeat (4) @(negedge clk);
    total++; if (store_cnt[0] !== s0) $display("FAIL ab_no_store: got %0d expected %0d", store_cnt[0], s0); else passed++;
    corrupt[0] = 16'h0;
    fill_src(0, 8'h60);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    total++; if (error[0] !== 1'b0) $display("FAIL ab_restart_clear: got %b expected 0", error[0]); else passed++;
    cyc = 0;
    while (!done[0] && cyc < 2000) begin @(negedge clk); cyc++; end
    total++; if (error[0] !== 1'b0) $display("FAIL ab_restart_error: got %b expected 0", error[0]); else passed++;
    check_ram(0, "ab_ram", 8'h60);
  endtask

  task automatic test_start_ignored();
    int cyc;
    fill_src(0, 8'h70);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 1;
    while (!(load[0] && bus_out[0] == 8'h04) && cyc < 200) begin @(negedge clk); cyc++; end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cyc++;
    total++; if ({store[0], bus_out[0]} !== {1'b1, 8'h74}) $display("FAIL ign_write4: got %b/%h expected 1/74", store[0], bus_out[0]); else passed++;
    while (!done[0] && cyc < 2000) begin @(negedge clk); cyc++; end
    total++; if (cyc !== 65) $display("FAIL ign_done_latency: got %0d expected 65", cyc); else passed++;
    check_ram(0, "ign_ram", 8'h70);
  endtask

  task automatic test_async_reset();
    int n, cyc;
    fill_src(0, 8'h80);
    corrupt[0] = 16'h0001;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (!(load[0] && bus_out[0] == 8'h02) && n < 200) begin @(negedge clk); n++; end
    total++; if ({load[0], error[0]} !== 2'b11) $display("FAIL rs_pre: got load/error %b expected 11", {load[0], error[0]}); else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({load[0], store[0], bus_oe[0], busy[0], done[0], error[0], err_addr[0]} !== 10'h0)
      $display("FAIL rs_immediate: got %b expected all zero", {load[0], store[0], bus_oe[0], busy[0], done[0], error[0], err_addr[0]});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    corrupt[0] = 16'h0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    total++; if ({load[0], bus_out[0]} !== {1'b1, 8'h00}) $display("FAIL rs_addr0: got %b/%h expected 1/00", load[0], bus_out[0]); else passed++;
    cyc = 0;
    while (!done[0] && cyc < 2000) begin @(negedge clk); cyc++; end
    total++; if (error[0] !== 1'b0) $display("FAIL rs_error: got %b expected 0", error[0]); else passed++;
    check_ram(0, "rs_ram", 8'h80);
    total++; if ({overlap[0], overlap[1]} !== 2'b00) $display("FAIL load_store_overlap: got %b expected 00", {overlap[0], overlap[1]}); else passed++;
  endtask

  initial begin
    test_reset();
    test_full_verify();
    test_no_verify();
    test_mismatch();
    test_backpressure();
    test_abort_restart();
    test_start_ignored();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
